// File: rtl/logic_unit_serial_pkg.sv
// Shared types for the serial bitwise logic unit: operation codes, FSM states
// and the slice-index width helper.
package logic_unit_serial_pkg;

   typedef enum logic [2:0] {
      OP_NOT  = 3'b000,
      OP_AND  = 3'b001,
      OP_OR   = 3'b010,
      OP_XOR  = 3'b011,
      OP_NOR  = 3'b100,
      OP_NAND = 3'b101,
      OP_XNOR = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Slice index needs at least one bit even when there is a single slice.
   function automatic int unsigned idx_width(input int unsigned nsl);
      return (nsl > 1) ? $clog2(nsl) : 1;
   endfunction

endpackage

// File: rtl/logic_unit_serial_if.sv
// Request/response bundle between an issuer (master) and the serial logic unit (slave).
interface logic_unit_serial_if
   import logic_unit_serial_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   op_e              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport master (output start, op, a, b, input busy, done, result, zero);
   modport slave  (input start, op, a, b, output busy, done, result, zero);
endinterface

// File: rtl/logic_unit_serial_slice.sv
// One slice of the bitwise datapath: per-bit gate primitives, then an op-selected mux.
module logic_unit_serial_slice
   import logic_unit_serial_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  op_e          op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   logic [W-1:0] not_c, and_c, or_c, xor_c, nor_c, nand_c, xnor_c;

   for (genvar i = 0; i < W; i++) begin : g_bit
      not  u_not  (not_c[i],  a_i[i]);
      and  u_and  (and_c[i],  a_i[i], b_i[i]);
      or   u_or   (or_c[i],   a_i[i], b_i[i]);
      xor  u_xor  (xor_c[i],  a_i[i], b_i[i]);
      nor  u_nor  (nor_c[i],  a_i[i], b_i[i]);
      nand u_nand (nand_c[i], a_i[i], b_i[i]);
      xnor u_xnor (xnor_c[i], a_i[i], b_i[i]);
   end

   always_comb begin
      y_o = a_i;
      case (op_i)
         OP_NOT:  y_o = not_c;
         OP_AND:  y_o = and_c;
         OP_OR:   y_o = or_c;
         OP_XOR:  y_o = xor_c;
         OP_NOR:  y_o = nor_c;
         OP_NAND: y_o = nand_c;
         OP_XNOR: y_o = xnor_c;
         OP_PASS: y_o = a_i;
         default: y_o = a_i;
      endcase
   end
endmodule

// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit: latches operands on start, evaluates SLICE bits per
// cycle LSB-first through a single shared slice, then registers result/zero with a done pulse.
module logic_unit_serial
   import logic_unit_serial_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input logic               clk,
   input logic               rst,
   logic_unit_serial_if.slave bus
);
   localparam int unsigned NSL   = WIDTH / SLICE;
   localparam int unsigned IDX_W = idx_width(NSL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   op_e              op_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
   logic             zero_q, busy_q, done_q;

   logic [SLICE-1:0] slice_a_c, slice_b_c, slice_y_c;
   logic [WIDTH-1:0] acc_d;

   // Operand slice select and accumulator merge for the current index.
   always_comb begin
      slice_a_c = a_q[idx_q*SLICE +: SLICE];
      slice_b_c = b_q[idx_q*SLICE +: SLICE];
      acc_d     = acc_q;
      acc_d[idx_q*SLICE +: SLICE] = slice_y_c;
   end

   logic_unit_serial_slice #(.W(SLICE)) u_slice (
      .op_i (op_q),
      .a_i  (slice_a_c),
      .b_i  (slice_b_c),
      .y_o  (slice_y_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         op_q     <= OP_NOT;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               busy_q <= 1'b0;
               if (bus.start) begin
                  state_q <= ST_BUSY;
                  busy_q  <= 1'b1;
                  idx_q   <= '0;
                  op_q    <= bus.op;
                  a_q     <= bus.a;
                  b_q     <= bus.b;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               acc_q <= acc_d;
               if (idx_q == LAST_IDX) begin
                  // Last slice lands in result on the same edge it is computed.
                  state_q  <= ST_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  idx_q    <= '0;
                  result_q <= acc_d;
                  zero_q   <= (acc_d == '0);
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.zero   = zero_q;
endmodule
